// File: rtl/hyperbus_phy_latency_fsm.sv
// HyperBus PHY transaction sequencer: drives CS# and the CA / latency / data / recovery phase strobes.
// Latency: accept in IDLE -> CA on the next clock; strobes are combinational decodes of the registered state.
// Backpressure: trans_ready_o only in IDLE; a write beat with tx_valid_i low aborts the burst with an error pulse.
//
// Ports: clk_i/rst_i (async active-high); trans_* request handshake and attributes;
// cfg_* pseudostatic timing config; rwds_sample_i registered RWDS from the sampler;
// tx_valid_i/tx_ready_o write-beat handshake; cs_no, ca_*, data_phase_o, beat_last_o,
// lat_2x_o phase strobes for the pad logic; trans_done_o/trans_error_o completion pulses.
module hyperbus_phy_latency_fsm #(
    parameter  int MaxLen   = 256,
    localparam int LenWidth = $clog2(MaxLen + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                trans_valid_i,
    output logic                trans_ready_o,
    input  logic                trans_write_i,
    input  logic                trans_reg_i,
    input  logic [LenWidth-1:0] trans_len_i,
    input  logic [3:0]          cfg_t_latency_i,
    input  logic                cfg_latency_fixed_i,
    input  logic [3:0]          cfg_sample_cycle_i,
    input  logic [3:0]          cfg_t_rwr_i,
    input  logic                rwds_sample_i,
    input  logic                tx_valid_i,
    output logic                cs_no,
    output logic                ca_valid_o,
    output logic [1:0]          ca_idx_o,
    output logic                data_phase_o,
    output logic                tx_ready_o,
    output logic                beat_last_o,
    output logic                lat_2x_o,
    output logic                trans_done_o,
    output logic                trans_error_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CA,
        S_LAT,
        S_DATA,
        S_RECOV
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            ca_idx_q, ca_idx_d;
    logic [4:0]            lat_cnt_q, lat_cnt_d;
    logic [LenWidth-1:0]   beat_cnt_q, beat_cnt_d;
    logic [LenWidth-1:0]   len_q, len_d;
    logic [3:0]            rec_cnt_q, rec_cnt_d;
    logic [3:0]            cs_cnt_q, cs_cnt_d;
    logic                  lat_flag_q, lat_flag_d;
    logic                  write_q, write_d;
    logic                  reg_q, reg_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [3:0]            tlat_eff;
    logic [3:0]            rwr_eff;
    logic [4:0]            lat_target;
    logic                  sample_win;
    logic                  underflow;
    logic [LenWidth-1:0]   len_sat;

    always_comb begin
        tlat_eff   = (cfg_t_latency_i == 4'd0) ? 4'd1 : cfg_t_latency_i;
        rwr_eff    = (cfg_t_rwr_i == 4'd0) ? 4'd1 : cfg_t_rwr_i;
        lat_target = lat_flag_q ? {tlat_eff, 1'b0} : {1'b0, tlat_eff};
        // The latency decision freezes at LAT count tlat-1 (the first point where
        // a 1x exit is possible); later RWDS samples cannot change it.
        sample_win = (state_q == S_CA) ||
                     ((state_q == S_LAT) && (lat_cnt_q < ({1'b0, tlat_eff} - 5'd1)));
        underflow  = (state_q == S_DATA) && write_q && !tx_valid_i;
        if (trans_len_i == '0) begin
            len_sat = LenWidth'(1);
        end else if (trans_len_i > LenWidth'(MaxLen)) begin
            len_sat = LenWidth'(MaxLen);
        end else begin
            len_sat = trans_len_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            ca_idx_q   <= '0;
            lat_cnt_q  <= '0;
            beat_cnt_q <= '0;
            len_q      <= '0;
            rec_cnt_q  <= '0;
            cs_cnt_q   <= '0;
            lat_flag_q <= 1'b0;
            write_q    <= 1'b0;
            reg_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ca_idx_q   <= ca_idx_d;
            lat_cnt_q  <= lat_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            rec_cnt_q  <= rec_cnt_d;
            cs_cnt_q   <= cs_cnt_d;
            lat_flag_q <= lat_flag_d;
            write_q    <= write_d;
            reg_q      <= reg_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ca_idx_d      = ca_idx_q;
        lat_cnt_d     = lat_cnt_q;
        beat_cnt_d    = beat_cnt_q;
        len_d         = len_q;
        rec_cnt_d     = rec_cnt_q;
        cs_cnt_d      = cs_cnt_q;
        lat_flag_d    = lat_flag_q;
        write_d       = write_q;
        reg_d         = reg_q;
        done_d        = 1'b0;
        err_d         = 1'b0;

        trans_ready_o = 1'b0;
        cs_no         = 1'b1;
        ca_valid_o    = 1'b0;
        ca_idx_o      = 2'd0;
        data_phase_o  = 1'b0;
        beat_last_o   = 1'b0;

        // CS-low cycle counter; IDLE/RECOV hold it at 0 so CA idx 0 sees 0.
        if ((state_q == S_CA) || (state_q == S_LAT) || (state_q == S_DATA)) begin
            if (cs_cnt_q != 4'd15) begin
                cs_cnt_d = cs_cnt_q + 4'd1;
            end
        end else begin
            cs_cnt_d = '0;
        end

        if (sample_win && (cs_cnt_q == cfg_sample_cycle_i)) begin
            lat_flag_d = rwds_sample_i | cfg_latency_fixed_i;
        end

        unique case (state_q)
            S_IDLE: begin
                trans_ready_o = 1'b1;
                if (trans_valid_i) begin
                    write_d    = trans_write_i;
                    reg_d      = trans_reg_i;
                    // Register writes carry exactly one beat whatever len says.
                    len_d      = (trans_write_i && trans_reg_i) ? LenWidth'(1) : len_sat;
                    lat_flag_d = 1'b1;
                    ca_idx_d   = '0;
                    state_d    = S_CA;
                end
            end
            S_CA: begin
                cs_no      = 1'b0;
                ca_valid_o = 1'b1;
                ca_idx_o   = ca_idx_q;
                if (ca_idx_q == 2'd2) begin
                    ca_idx_d   = '0;
                    lat_cnt_d  = '0;
                    beat_cnt_d = '0;
                    state_d    = (write_q && reg_q) ? S_DATA : S_LAT;
                end else begin
                    ca_idx_d = ca_idx_q + 2'd1;
                end
            end
            S_LAT: begin
                cs_no = 1'b0;
                if (lat_cnt_q == (lat_target - 5'd1)) begin
                    lat_cnt_d = '0;
                    state_d   = S_DATA;
                end else begin
                    lat_cnt_d = lat_cnt_q + 5'd1;
                end
            end
            S_DATA: begin
                cs_no        = 1'b0;
                data_phase_o = !underflow;
                beat_last_o  = !underflow && (beat_cnt_q == (len_q - LenWidth'(1)));
                rec_cnt_d    = '0;
                if (underflow) begin
                    err_d   = 1'b1;
                    state_d = S_RECOV;
                end else if (beat_cnt_q == (len_q - LenWidth'(1))) begin
                    done_d  = 1'b1;
                    state_d = S_RECOV;
                end else begin
                    beat_cnt_d = beat_cnt_q + LenWidth'(1);
                end
            end
            S_RECOV: begin
                if (rec_cnt_q == (rwr_eff - 4'd1)) begin
                    rec_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    rec_cnt_d = rec_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_ready_o    = data_phase_o & write_q;
    assign lat_2x_o      = lat_flag_q;
    assign trans_done_o  = done_q;
    assign trans_error_o = err_q;

endmodule

// File: tb/tb_hyperbus_phy_latency_fsm.sv
module tb_hyperbus_phy_latency_fsm;

    localparam int LW = 9;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          trans_valid_i;
    logic          trans_ready_o;
    logic          trans_write_i;
    logic          trans_reg_i;
    logic [LW-1:0] trans_len_i;
    logic [3:0]    cfg_t_latency_i;
    logic          cfg_latency_fixed_i;
    logic [3:0]    cfg_sample_cycle_i;
    logic [3:0]    cfg_t_rwr_i;
    logic          rwds_sample_i;
    logic          tx_valid_i;
    logic          cs_no;
    logic          ca_valid_o;
    logic [1:0]    ca_idx_o;
    logic          data_phase_o;
    logic          tx_ready_o;
    logic          beat_last_o;
    logic          lat_2x_o;
    logic          trans_done_o;
    logic          trans_error_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-transaction observations
    int n_ca, n_lat, n_data, n_txr, n_last, last_pos, n_done, n_err;
    int n_cslow, n_recov, lat2x_seen, cs_at_err;
    logic tmo;

    hyperbus_phy_latency_fsm #(.MaxLen(256)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .trans_valid_i       (trans_valid_i),
        .trans_ready_o       (trans_ready_o),
        .trans_write_i       (trans_write_i),
        .trans_reg_i         (trans_reg_i),
        .trans_len_i         (trans_len_i),
        .cfg_t_latency_i     (cfg_t_latency_i),
        .cfg_latency_fixed_i (cfg_latency_fixed_i),
        .cfg_sample_cycle_i  (cfg_sample_cycle_i),
        .cfg_t_rwr_i         (cfg_t_rwr_i),
        .rwds_sample_i       (rwds_sample_i),
        .tx_valid_i          (tx_valid_i),
        .cs_no               (cs_no),
        .ca_valid_o          (ca_valid_o),
        .ca_idx_o            (ca_idx_o),
        .data_phase_o        (data_phase_o),
        .tx_ready_o          (tx_ready_o),
        .beat_last_o         (beat_last_o),
        .lat_2x_o            (lat_2x_o),
        .trans_done_o        (trans_done_o),
        .trans_error_o       (trans_error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one request and watch it until the block is back in IDLE.
    // drop_beat (1-based) is the write beat on which tx_valid_i goes low; 0 = never.
    task automatic run_trans(input logic w, input logic r, input logic [LW-1:0] len,
                             input logic rw, input int drop_beat, input int budget);
        @(negedge clk_i);
        trans_valid_i = 1'b1;
        trans_write_i = w;
        trans_reg_i   = r;
        trans_len_i   = len;
        rwds_sample_i = rw;
        tx_valid_i    = 1'b1;
        @(negedge clk_i);
        trans_valid_i = 1'b0;
        n_ca = 0; n_lat = 0; n_data = 0; n_txr = 0; n_last = 0; last_pos = 0;
        n_done = 0; n_err = 0; n_cslow = 0; n_recov = 0; lat2x_seen = 0; cs_at_err = -1;
        tmo = 1'b1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            tx_valid_i = ((n_txr + 1) != drop_beat);
            #1;
            if (trans_ready_o) begin
                tmo = 1'b0;
                break;
            end
            if (!cs_no) n_cslow++;
            if (cs_no) n_recov++;
            if (ca_valid_o) begin
                check_val("ca_idx", int'(ca_idx_o), n_ca);
                n_ca++;
            end
            if (!cs_no && !ca_valid_o && !data_phase_o) begin
                n_lat++;
                if (lat_2x_o) lat2x_seen = 1;
            end
            if (data_phase_o) n_data++;
            if (tx_ready_o) n_txr++;
            if (beat_last_o) begin
                n_last++;
                last_pos = n_data;
            end
            if (trans_done_o) n_done++;
            if (trans_error_o) begin
                n_err++;
                cs_at_err = int'(cs_no);
            end
            @(negedge clk_i);
        end
        check_val("timeout", int'(tmo), 0);
    endtask

    initial begin
        rst_i               = 1'b1;
        trans_valid_i       = 1'b0;
        trans_write_i       = 1'b0;
        trans_reg_i         = 1'b0;
        trans_len_i         = '0;
        cfg_t_latency_i     = 4'd6;
        cfg_latency_fixed_i = 1'b0;
        cfg_sample_cycle_i  = 4'd2;
        cfg_t_rwr_i         = 4'd3;
        rwds_sample_i       = 1'b0;
        tx_valid_i          = 1'b0;

        repeat (3) @(negedge clk_i);
        check_val("rst_cs_no", int'(cs_no), 1);
        check_val("rst_ready", int'(trans_ready_o), 1);
        check_val("rst_ca_valid", int'(ca_valid_o), 0);
        check_val("rst_data_phase", int'(data_phase_o), 0);
        check_val("rst_lat_2x", int'(lat_2x_o), 0);
        check_val("rst_done", int'(trans_done_o), 0);
        rst_i = 1'b0;

        // 1x read: 3 CA + 6 LAT + 4 DATA = 13 CS-low cycles
        run_trans(1'b0, 1'b0, 9'd4, 1'b0, 0, 100);
        check_val("t1_ca", n_ca, 3);
        check_val("t1_lat", n_lat, 6);
        check_val("t1_data", n_data, 4);
        check_val("t1_last_cnt", n_last, 1);
        check_val("t1_last_pos", last_pos, 4);
        check_val("t1_cslow", n_cslow, 13);
        check_val("t1_recov", n_recov, 3);
        check_val("t1_done", n_done, 1);
        check_val("t1_err", n_err, 0);
        check_val("t1_lat2x", lat2x_seen, 0);
        check_val("t1_txr", n_txr, 0);

        // 2x read via RWDS=1 at cs_cnt 2: LAT 12, CS low 19
        run_trans(1'b0, 1'b0, 9'd4, 1'b1, 0, 100);
        check_val("t2_lat", n_lat, 12);
        check_val("t2_cslow", n_cslow, 19);
        check_val("t2_lat2x", lat2x_seen, 1);
        check_val("t2_done", n_done, 1);

        // Register write: len ignored, one beat, no latency
        run_trans(1'b1, 1'b1, 9'd8, 1'b0, 0, 100);
        check_val("t3_ca", n_ca, 3);
        check_val("t3_lat", n_lat, 0);
        check_val("t3_data", n_data, 1);
        check_val("t3_txr", n_txr, 1);
        check_val("t3_cslow", n_cslow, 4);
        check_val("t3_last_cnt", n_last, 1);
        check_val("t3_done", n_done, 1);

        // Write underflow on the 3rd beat
        run_trans(1'b1, 1'b0, 9'd4, 1'b0, 3, 100);
        check_val("t4_txr", n_txr, 2);
        check_val("t4_err", n_err, 1);
        check_val("t4_done", n_done, 0);
        check_val("t4_cs_at_err", cs_at_err, 1);
        check_val("t4_cslow", n_cslow, 12);
        check_val("t4_last_cnt", n_last, 0);

        // Sample point beyond the freeze point: stays 2x
        cfg_sample_cycle_i = 4'd15;
        cfg_t_latency_i    = 4'd3;
        run_trans(1'b0, 1'b0, 9'd2, 1'b0, 0, 100);
        check_val("t5_lat", n_lat, 6);
        check_val("t5_lat2x", lat2x_seen, 1);
        check_val("t5_cslow", n_cslow, 11);

        // Asynchronous reset in the middle of LAT
        cfg_sample_cycle_i = 4'd2;
        cfg_t_latency_i    = 4'd6;
        @(negedge clk_i);
        trans_valid_i = 1'b1;
        trans_write_i = 1'b0;
        trans_reg_i   = 1'b0;
        trans_len_i   = 9'd4;
        @(negedge clk_i);
        trans_valid_i = 1'b0;
        repeat (4) @(negedge clk_i);
        #1;
        check_val("t6_pre_cs_no", int'(cs_no), 0);
        check_val("t6_pre_ca_valid", int'(ca_valid_o), 0);
        #2;
        rst_i = 1'b1;
        #1;
        check_val("t6_rst_cs_no", int'(cs_no), 1);
        check_val("t6_rst_ready", int'(trans_ready_o), 1);
        check_val("t6_rst_lat2x", int'(lat_2x_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_val("t6_post_done", int'(trans_done_o), 0);

        // Boundaries after reset: len 0 -> 1 beat, t_latency 0 -> 1, t_rwr 0 -> 1
        cfg_t_latency_i = 4'd0;
        cfg_t_rwr_i     = 4'd0;
        run_trans(1'b0, 1'b0, 9'd0, 1'b0, 0, 100);
        check_val("t7_lat", n_lat, 1);
        check_val("t7_data", n_data, 1);
        check_val("t7_cslow", n_cslow, 5);
        check_val("t7_recov", n_recov, 1);
        check_val("t7_done", n_done, 1);

        // Length above MaxLen saturates to 256 beats
        cfg_t_latency_i = 4'd1;
        run_trans(1'b0, 1'b0, 9'd300, 1'b0, 0, 400);
        check_val("t8_data", n_data, 256);
        check_val("t8_last_pos", last_pos, 256);
        check_val("t8_cslow", n_cslow, 260);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
